// File: rtl/knn_vote_pkg.sv
// ============================================================================
//  knn_vote_pkg : shared state encoding and width helpers for knn_vote
//  Revision     : 1.0
// ============================================================================
`default_nettype none

package knn_vote_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_SCAN  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Index width that stays at least one bit for single-entry ranges.
   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/knn_vote_argmax.sv
// ============================================================================
//  knn_vote_argmax : running best-count/best-class keep register for SCAN
//  Optional macro KNN_VOTE_NEAREST_TIE_EN: equal counts go to nearer class
//  Revision        : 1.0
// ============================================================================
`default_nettype none

module knn_vote_argmax
   import knn_vote_pkg::*;
#(
   parameter int LABEL = 8,
`ifdef KNN_VOTE_NEAREST_TIE_EN
   parameter int SLOT_W = 4,
`endif
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic [CNT_W-1:0] i_cnt,
   input  logic [LABEL-1:0] i_cls,
`ifdef KNN_VOTE_NEAREST_TIE_EN
   input  logic [SLOT_W-1:0] i_first,
`endif
   output logic [CNT_W-1:0] o_best_cnt,
   output logic [LABEL-1:0] o_best_cls
);

   logic [CNT_W-1:0] r_best_cnt;
   logic [LABEL-1:0] r_best_cls;
   logic             w_take;

`ifdef KNN_VOTE_NEAREST_TIE_EN
   logic [SLOT_W-1:0] r_best_first;

   // Zero-count classes never win a tie, so all-ones survives an empty vote.
   always_comb begin
      w_take = (i_cnt > r_best_cnt) ||
               ((i_cnt == r_best_cnt) && (i_cnt != '0) && (i_first < r_best_first));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_first <= '1;
      end else if (i_clr) begin
         r_best_first <= '1;
      end else if (i_en && w_take) begin
         r_best_first <= i_first;
      end
   end
`else
   always_comb begin
      w_take = (i_cnt > r_best_cnt);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_cnt <= '0;
         r_best_cls <= '1;
      end else if (i_clr) begin
         r_best_cnt <= '0;
         r_best_cls <= '1;
      end else if (i_en && w_take) begin
         r_best_cnt <= i_cnt;
         r_best_cls <= i_cls;
      end
   end

   assign o_best_cnt = r_best_cnt;
   assign o_best_cls = r_best_cls;

endmodule

`default_nettype wire

// File: rtl/knn_vote.sv
// ============================================================================
//  knn_vote : majority-vote classifier over the N nearest neighbour labels
//  Optional macro KNN_VOTE_NEAREST_TIE_EN: nearest-first-occurrence tie-break
//  Revision : 1.0
// ============================================================================
`default_nettype none

module knn_vote
   import knn_vote_pkg::*;
#(
   parameter int LABEL       = 8,
   parameter int N_Neighbour = 10,
   parameter int N_CLASSES   = 10
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               start,
   input  logic [LABEL*N_Neighbour-1:0]       Neighbour_info,
   output logic                               busy,
   output logic                               done,
   output logic [LABEL-1:0]                   class_out,
   output logic [$clog2(N_Neighbour+1)-1:0]   votes_out,
   output logic                               no_class
);

   localparam int c_cnt_w  = $clog2(N_Neighbour + 1);
   localparam int c_cls_w  = width_of(N_CLASSES);
   localparam int c_slot_w = width_of(N_Neighbour);
   localparam int c_idx_w  = max_int(c_cls_w, c_slot_w);

   state_t                       r_state;
   logic [LABEL*N_Neighbour-1:0] r_shadow;
   logic [c_idx_w-1:0]           r_idx;
   logic [c_cnt_w-1:0]           r_cnt [N_CLASSES];

   logic [LABEL-1:0]   w_label;
   logic               w_valid;
   logic [c_cls_w-1:0] w_lbl_cls;
   logic [c_cls_w-1:0] w_scan_cls;
   logic               w_last_slot;
   logic               w_last_cls;
   logic [c_cnt_w-1:0] w_best_cnt;
   logic [LABEL-1:0]   w_best_cls;

   assign w_label     = r_shadow[r_idx*LABEL +: LABEL];
   assign w_valid     = (w_label < LABEL'(N_CLASSES));
   assign w_lbl_cls   = w_label[c_cls_w-1:0];
   assign w_scan_cls  = r_idx[c_cls_w-1:0];
   assign w_last_slot = (r_idx == c_idx_w'(N_Neighbour - 1));
   assign w_last_cls  = (r_idx == c_idx_w'(N_CLASSES - 1));

`ifdef KNN_VOTE_NEAREST_TIE_EN
   logic [c_slot_w-1:0] r_first [N_CLASSES];
   logic [c_slot_w-1:0] w_slot;

   assign w_slot = r_idx[c_slot_w-1:0];

   // Only the first hit of a class records its slot; later hits are farther.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_CLASSES; i++) r_first[i] <= '1;
      end else if (r_state == ST_COUNT && w_valid && r_cnt[w_lbl_cls] == '0) begin
         r_first[w_lbl_cls] <= w_slot;
      end
   end
`endif

   knn_vote_argmax #(
      .LABEL  (LABEL),
`ifdef KNN_VOTE_NEAREST_TIE_EN
      .SLOT_W (c_slot_w),
`endif
      .CNT_W  (c_cnt_w)
   ) u_argmax (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_clr      (r_state == ST_COUNT),
      .i_en       (r_state == ST_SCAN),
      .i_cnt      (r_cnt[w_scan_cls]),
      .i_cls      (LABEL'(r_idx)),
`ifdef KNN_VOTE_NEAREST_TIE_EN
      .i_first    (r_first[w_scan_cls]),
`endif
      .o_best_cnt (w_best_cnt),
      .o_best_cls (w_best_cls)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_shadow  <= '0;
         r_idx     <= '0;
         for (int i = 0; i < N_CLASSES; i++) r_cnt[i] <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         class_out <= '1;
         votes_out <= '0;
         no_class  <= 1'b1;
      end else begin
         done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_shadow <= Neighbour_info;
                  for (int i = 0; i < N_CLASSES; i++) r_cnt[i] <= '0;
                  r_idx    <= '0;
                  busy     <= 1'b1;
                  r_state  <= ST_COUNT;
               end
            end
            ST_COUNT: begin
               if (w_valid) r_cnt[w_lbl_cls] <= r_cnt[w_lbl_cls] + c_cnt_w'(1);
               if (w_last_slot) begin
                  r_idx   <= '0;
                  r_state <= ST_SCAN;
               end else begin
                  r_idx <= r_idx + c_idx_w'(1);
               end
            end
            ST_SCAN: begin
               if (w_last_cls) r_state <= ST_DONE;
               else            r_idx   <= r_idx + c_idx_w'(1);
            end
            ST_DONE: begin
               class_out <= w_best_cls;
               votes_out <= w_best_cnt;
               no_class  <= (w_best_cnt == '0);
               done      <= 1'b1;
               busy      <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_knn_vote.sv
// Bench for knn_vote: directed and random votes against a counting reference model.
// Define KNN_VOTE_NEAREST_TIE_EN for both bench and RTL to exercise the nearest tie-break.
`default_nettype none

module tb_knn_vote;

   localparam int LABEL = 8;
   localparam int NN    = 10;
   localparam int NC    = 10;
`ifdef KNN_VOTE_NEAREST_TIE_EN
   localparam bit TIE_NEAR = 1'b1;
`else
   localparam bit TIE_NEAR = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  start = 1'b0;
   logic [LABEL*NN-1:0]   info = '0;
   logic                  busy, done, no_class;
   logic [LABEL-1:0]      class_out;
   logic [3:0]            votes_out;

   int n_cmp  = 0;
   int n_fail = 0;

   knn_vote #(.LABEL(LABEL), .N_Neighbour(NN), .N_CLASSES(NC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .Neighbour_info (info),
      .busy           (busy),
      .done           (done),
      .class_out      (class_out),
      .votes_out      (votes_out),
      .no_class       (no_class)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LABEL*NN-1:0] pack(input int l[NN]);
      logic [LABEL*NN-1:0] v;
      v = '0;
      for (int s = 0; s < NN; s++) v[s*LABEL +: LABEL] = LABEL'(l[s]);
      return v;
   endfunction

   // Majority vote straight from the rules: tally, then ascending class scan.
   function automatic void model(input logic [LABEL*NN-1:0] inf, output logic [7:0] cls,
                                 output logic [3:0] votes, output logic nc);
      int cnt[NC];
      int first[NC];
      int best, bcls, bfirst, l;
      for (int c = 0; c < NC; c++) begin cnt[c] = 0; first[c] = NN; end
      for (int s = 0; s < NN; s++) begin
         l = int'(inf[s*LABEL +: LABEL]);
         if (l < NC) begin
            if (cnt[l] == 0) first[l] = s;
            cnt[l]++;
         end
      end
      best = 0; bcls = -1; bfirst = NN;
      for (int c = 0; c < NC; c++) begin
         if (cnt[c] > best || (TIE_NEAR && cnt[c] == best && best > 0 && first[c] < bfirst)) begin
            best = cnt[c]; bcls = c; bfirst = first[c];
         end
      end
      cls   = (bcls < 0) ? 8'hFF : 8'(bcls);
      votes = 4'(best);
      nc    = (best == 0);
   endfunction

   task automatic run_vote(input string tag, input logic [LABEL*NN-1:0] inf, input bit scramble);
      logic [7:0] ec;
      logic [3:0] ev;
      logic       en;
      int         cyc;
      bit         seen;
      model(inf, ec, ev, en);
      @(negedge clk); info = inf; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({tag, ".busy"}, busy, 1);
      if (scramble) info = {16'($urandom), $urandom, $urandom};
      cyc = 1; seen = 0;
      while (cyc <= 40 && !seen) begin
         @(negedge clk);
         if (done) seen = 1; else cyc++;
      end
      chk({tag, ".done_seen"}, seen, 1);
      chk({tag, ".latency"}, cyc, 21);
      chk({tag, ".class"}, class_out, ec);
      chk({tag, ".votes"}, votes_out, ev);
      chk({tag, ".no_class"}, no_class, en);
      chk({tag, ".busy_low"}, busy, 0);
      @(negedge clk);
      chk({tag, ".done_pulse"}, done, 0);
      chk({tag, ".hold"}, class_out, ec);
   endtask

   initial begin
      logic [7:0] ec;
      logic [3:0] ev;
      logic       en;
      int         l[NN];
      int         c, d1, d2, n_done;

      #12;
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.class", class_out, 8'hFF);
      chk("rst.votes", votes_out, 0);
      chk("rst.no_class", no_class, 1);
      @(negedge clk); rst_n = 1'b1;

      run_vote("example", pack('{3,3,1,3,7,1,3,2,3,0}), 1'b0);
      chk("example.const_class", class_out, 8'd3);
      chk("example.const_votes", votes_out, 4'd5);

      run_vote("all_ff", pack('{255,255,255,255,255,255,255,255,255,255}), 1'b0);
      chk("all_ff.const_class", class_out, 8'hFF);

      run_vote("tie9", pack('{5,2,5,2,9,9,9,9,9,9}), 1'b0);
      chk("tie9.const_class", class_out, 8'd9);
      run_vote("tie52", pack('{5,2,5,2,255,255,255,255,255,255}), 1'b0);
      chk("tie52.const_class", class_out, TIE_NEAR ? 8'd5 : 8'd2);
      chk("tie52.const_votes", votes_out, 4'd2);

      run_vote("lbl10", pack('{10,10,10,10,10,4,4,4,4,4}), 1'b0);
      chk("lbl10.const_class", class_out, 8'd4);

      repeat (12) begin
         for (int s = 0; s < NN; s++)
            l[s] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 11));
         run_vote("random", pack(l), 1'b1);
      end

      // start held high: back-to-back votes every 22 cycles
      for (int s = 0; s < NN; s++) l[s] = int'($urandom_range(0, 9));
      info = pack(l);
      model(info, ec, ev, en);
      @(negedge clk); start = 1'b1;
      c = -1; d1 = -1; d2 = -1;
      while (c < 60 && d2 < 0) begin
         @(negedge clk); c++;
         if (done) begin
            if (d1 < 0) d1 = c;
            else begin d2 = c; start = 1'b0; end
         end
      end
      start = 1'b0;
      chk("held.first_done", d1, 21);
      chk("held.second_done", d2, 43);
      chk("held.class", class_out, ec);
      chk("held.votes", votes_out, ev);
      repeat (3) @(negedge clk);
      chk("held.idle", busy, 0);

      // asynchronous reset during COUNT
      run_vote("pre_reset", pack('{1,1,1,2,2,3,4,5,6,7}), 1'b0);
      @(negedge clk); info = pack('{6,6,6,6,6,6,6,6,6,6}); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.busy", busy, 0);
      chk("midrst.done", done, 0);
      chk("midrst.class", class_out, 8'hFF);
      chk("midrst.votes", votes_out, 0);
      chk("midrst.no_class", no_class, 1);
      @(negedge clk); rst_n = 1'b1;
      n_done = 0;
      repeat (30) begin
         @(negedge clk);
         if (done) n_done++;
      end
      chk("midrst.no_late_done", n_done, 0);
      chk("midrst.class_held", class_out, 8'hFF);

      run_vote("recover", pack('{8,0,8,0,8,0,8,255,10,11}), 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
